// File: rtl/cache_axi_bridge_pkg.sv
// cache_axi_bridge_pkg
// Shared definitions for the cache refill/write-back engine: the constant
// AXI4 burst attributes it drives and the encoding of its control FSM.
package cache_axi_bridge_pkg;

    // Beats-minus-one for a 16-beat line burst.
    localparam logic [7:0] LEN16      = 8'd15;
    // 4-byte beats on the 32-bit data bus.
    localparam logic [2:0] SIZE4B     = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] WSTRB_ALL  = 4'hf;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB_AW = 3'd1,
        S_WB_W  = 3'd2,
        S_WB_B  = 3'd3,
        S_RD_AR = 3'd4,
        S_RD_R  = 3'd5,
        S_FILL  = 3'd6
    } state_e;

endpackage

// File: rtl/cache_axi_bridge_chk.sv
// cache_axi_bridge_chk
// Protocol checker for the cache side of the bridge: the cache must not
// issue a new write-back while the single write-back slot is occupied.
// Ports: clk, rst, wen_back_i (write-back pulse), wb_pend_i (slot busy).
module cache_axi_bridge_chk (
    input  logic clk,
    input  logic rst,
    input  logic wen_back_i,
    input  logic wb_pend_i
);

    a_no_wb_overrun: assert property (@(posedge clk) disable iff (rst)
        !(wen_back_i && wb_pend_i))
        else $error("write-back pulse while write-back slot occupied");

endmodule

// File: rtl/cache_axi_bridge_line_beat_buf.sv
// line_beat_buf
// One cache line held as LINE_WORDS 32-bit words. The whole line can be
// loaded at once (write-back capture), single words can be written by beat
// index (refill assembly), and one word can be selected by beat index
// (write-back beat streaming).
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears line)
//   load_i, line_i  full-line load
//   wr_en_i, wr_idx_i, wr_word_i   single-word write
//   sel_idx_i, sel_word_o          word select
//   line_o          current line contents
module line_beat_buf #(
    parameter int LINE_WORDS = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_i,
    input  logic [32*LINE_WORDS-1:0]             line_i,
    input  logic                                 wr_en_i,
    input  logic [$clog2(LINE_WORDS)-1:0]        wr_idx_i,
    input  logic [31:0]                          wr_word_i,
    input  logic [$clog2(LINE_WORDS)-1:0]        sel_idx_i,
    output logic [31:0]                          sel_word_o,
    output logic [32*LINE_WORDS-1:0]             line_o
);

    logic [32*LINE_WORDS-1:0] line_q;

    // Line storage: full load wins over a single-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= line_i;
        end else if (wr_en_i) begin
            line_q[32*wr_idx_i +: 32] <= wr_word_i;
        end
    end

    assign sel_word_o = line_q[32*sel_idx_i +: 32];
    assign line_o     = line_q;

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
// Memory-side refill/write-back engine behind the data cache. Captures one
// write-back (line + address) and one miss (line address), runs each as a
// LINE_WORDS-beat INCR burst on a 32-bit AXI4 master port, returns refilled
// lines as a one-cycle fill and acknowledges write-backs with fin.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wen_back, waddr, wback, fin      write-back request / completion
//   miss, miss_addr, accept          refill request / capture pulse
//   wen_fill, wfill                  refilled line
//   ar*, r*, aw*, w*, b*             AXI4 master channels
//   bus_err                          sticky debug flag: non-OKAY response seen
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wen_back,
    input  logic [31:0]                 waddr,
    input  logic [32*LINE_WORDS-1:0]    wback,
    output logic                        fin,
    input  logic                        miss,
    input  logic [31:0]                 miss_addr,
    output logic                        accept,
    output logic                        wen_fill,
    output logic [32*LINE_WORDS-1:0]    wfill,
    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [3:0]                  wid,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic                        bus_err
);

    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               wb_pend_q;
    logic               rd_pend_q;
    logic [31:0]        wb_addr_q;
    logic [31:0]        rd_addr_q;
    logic               bus_err_q;
    logic               arvalid_q, awvalid_q, wvalid_q, wlast_q;
    logic               rready_q, bready_q;
    logic               accept_q, fin_q, wen_fill_q;
    logic [31:0]        araddr_q, awaddr_q, wdata_q;

    logic               wb_load_s;
    logic               rd_wr_s;
    logic [IDX_W-1:0]   wb_sel_idx_s;
    logic [31:0]        wb_word_s;
    logic [31:0]        rd_word_s;
    logic [32*LINE_WORDS-1:0] wb_line_s;
    logic [32*LINE_WORDS-1:0] rd_line_s;

    assign wb_load_s = wen_back && !wb_pend_q;
    assign rd_wr_s   = (state_q == S_RD_R) && rvalid;

    // Word to present on the next W beat: beat 0 when leaving AW, else cnt+1.
    always_comb begin
        wb_sel_idx_s = '0;
        if (state_q == S_WB_W) begin
            wb_sel_idx_s = cnt_q + IDX_W'(1);
        end else begin
            wb_sel_idx_s = '0;
        end
    end

    line_beat_buf #(.LINE_WORDS(LINE_WORDS)) u_wb_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wb_load_s),
        .line_i     (wback),
        .wr_en_i    (1'b0),
        .wr_idx_i   ('0),
        .wr_word_i  (32'd0),
        .sel_idx_i  (wb_sel_idx_s),
        .sel_word_o (wb_word_s),
        .line_o     (wb_line_s)
    );

    line_beat_buf #(.LINE_WORDS(LINE_WORDS)) u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .line_i     ('0),
        .wr_en_i    (rd_wr_s),
        .wr_idx_i   (cnt_q),
        .wr_word_i  (rdata),
        .sel_idx_i  (cnt_q),
        .sel_word_o (rd_word_s),
        .line_o     (rd_line_s)
    );

    cache_axi_bridge_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .wen_back_i (wen_back),
        .wb_pend_i  (wb_pend_q)
    );

    // Slots, control FSM and all registered AXI/cache-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wb_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            wb_addr_q  <= 32'd0;
            rd_addr_q  <= 32'd0;
            bus_err_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            rready_q   <= 1'b0;
            bready_q   <= 1'b0;
            accept_q   <= 1'b0;
            fin_q      <= 1'b0;
            wen_fill_q <= 1'b0;
            araddr_q   <= 32'd0;
            awaddr_q   <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            accept_q   <= 1'b0;
            fin_q      <= 1'b0;
            wen_fill_q <= 1'b0;

            // A write-back arriving while the slot is busy is dropped.
            if (wb_load_s) begin
                wb_pend_q <= 1'b1;
                wb_addr_q <= waddr;
            end
            // miss is a level: capture only into a free slot so it acks once.
            if (miss && !rd_pend_q) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= miss_addr;
                accept_q  <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // Write-back first so a refill never reads a stale line.
                    if (wb_pend_q) begin
                        state_q   <= S_WB_AW;
                        awvalid_q <= 1'b1;
                        awaddr_q  <= wb_addr_q;
                    end else if (rd_pend_q) begin
                        state_q   <= S_RD_AR;
                        arvalid_q <= 1'b1;
                        araddr_q  <= rd_addr_q;
                    end
                end
                S_WB_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= wb_word_s;
                        wlast_q   <= (LAST_IDX == '0);
                        cnt_q     <= '0;
                        state_q   <= S_WB_W;
                    end
                end
                S_WB_W: begin
                    if (wready) begin
                        if (cnt_q == LAST_IDX) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_WB_B;
                        end else begin
                            cnt_q   <= cnt_q + IDX_W'(1);
                            wdata_q <= wb_word_s;
                            wlast_q <= ((cnt_q + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                S_WB_B: begin
                    if (bvalid) begin
                        bready_q  <= 1'b0;
                        fin_q     <= 1'b1;
                        wb_pend_q <= 1'b0;
                        if (bresp != RESP_OKAY) begin
                            bus_err_q <= 1'b1;
                        end
                        state_q   <= S_IDLE;
                    end
                end
                S_RD_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (rvalid) begin
                        if (rresp != RESP_OKAY) begin
                            bus_err_q <= 1'b1;
                        end
                        // Early rlast ends the burst; a missing one is forced at the last beat.
                        if (rlast || (cnt_q == LAST_IDX)) begin
                            rready_q   <= 1'b0;
                            wen_fill_q <= 1'b1;
                            state_q    <= S_FILL;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    rd_pend_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign arid     = AXI_ID;
    assign awid     = AXI_ID;
    assign wid      = AXI_ID;
    assign arlen    = LEN16;
    assign awlen    = LEN16;
    assign arsize   = SIZE4B;
    assign awsize   = SIZE4B;
    assign arburst  = BURST_INCR;
    assign awburst  = BURST_INCR;
    assign wstrb    = WSTRB_ALL;
    assign araddr   = araddr_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign awaddr   = awaddr_q;
    assign awvalid  = awvalid_q;
    assign wdata    = wdata_q;
    assign wlast    = wlast_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;
    assign accept   = accept_q;
    assign fin      = fin_q;
    assign wen_fill = wen_fill_q;
    assign wfill    = rd_line_s;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge with a behavioural AXI4
// slave (optional random stalls, injectable SLVERR) and a valid/stability
// monitor on the master's AR/AW/W channels.
module tb_cache_axi_bridge;
    import cache_axi_bridge_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         wen_back = 1'b0;
    logic [31:0]  waddr = 32'd0;
    logic [511:0] wback = '0;
    logic         fin;
    logic         miss = 1'b0;
    logic [31:0]  miss_addr = 32'd0;
    logic         accept, wen_fill;
    logic [511:0] wfill;
    logic [3:0]   arid, awid, wid, wstrb;
    logic [31:0]  araddr, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, rready, awvalid, wlast, wvalid, bready, bus_err;
    logic         arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]  rdata = 32'd0;
    logic [1:0]   rresp = 2'b00, bresp = 2'b00;

    cache_axi_bridge #(.AXI_ID(4'd0), .LINE_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .wen_back(wen_back), .waddr(waddr), .wback(wback), .fin(fin),
        .miss(miss), .miss_addr(miss_addr), .accept(accept),
        .wen_fill(wen_fill), .wfill(wfill),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave configuration and event logs
    int           stall_max = 0;
    int           err_beat  = -1;
    int           cyc = 0;
    int           ar_cyc = 0, aw_cyc = 0, fin_cyc = 0, fill_cyc = 0;
    int           fin_cnt = 0, fill_cnt = 0, ar_hs_cnt = 0, viol = 0;
    logic [31:0]  ar_addr_log = 32'd0, aw_addr_log = 32'd0;
    logic [511:0] fill_line = '0;
    logic [511:0] exp_wb = '0;

    // Slave internal state
    logic         r_active = 1'b0, w_active = 1'b0, b_pend = 1'b0;
    int           r_beat = 0, w_beat = 0;
    int           ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0]  r_addr = 32'd0;
    logic         p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
    logic         p_wv = 1'b0, p_wr = 1'b0, p_wl = 1'b0;
    logic [31:0]  p_ara = 32'd0, p_awa = 32'd0, p_wd = 32'd0;

    function automatic int rnd();
        if (stall_max == 0) return 0;
        return int'($urandom_range(stall_max, 0));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // AXI slave + monitor: decide at negedge what the next posedge sees.
    always @(negedge clk) begin
        if (rst) begin
            r_active = 1'b0; w_active = 1'b0; b_pend = 1'b0;
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'b00;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
        end else begin
            if (p_arv && !p_arr && (!arvalid || araddr != p_ara)) viol++;
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awa)) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wd || wlast != p_wl)) viol++;
            if (arvalid && !p_arv) begin ar_cyc = cyc; ar_addr_log = araddr; end
            if (awvalid && !p_awv) begin aw_cyc = cyc; aw_addr_log = awaddr; end
            if (fin) begin fin_cnt++; fin_cyc = cyc; end
            if (wen_fill) begin fill_cnt++; fill_cyc = cyc; fill_line = wfill; end

            // R before AR so no beat is offered before the AR handshake.
            if (r_active) begin
                if (r_wait > 0) begin
                    rvalid = 1'b0; r_wait--;
                end else begin
                    rvalid = 1'b1;
                    rdata  = {r_addr[15:0], 16'h0000} + 32'(r_beat);
                    rlast  = (r_beat == 15);
                    rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
                    if (rready) begin
                        r_beat++; r_wait = rnd();
                        if (r_beat == 16) r_active = 1'b0;
                    end
                end
            end else begin
                rvalid = 1'b0; rlast = 1'b0;
            end
            if (arvalid && !r_active) begin
                if (ar_wait > 0) begin
                    arready = 1'b0; ar_wait--;
                end else begin
                    arready = 1'b1; r_active = 1'b1; r_addr = araddr;
                    r_beat = 0; r_wait = rnd(); ar_hs_cnt++;
                end
            end else begin
                arready = 1'b0;
                if (!arvalid) ar_wait = rnd();
            end

            // B before W so the response follows the last W handshake.
            if (b_pend) begin
                if (b_wait > 0) begin
                    bvalid = 1'b0; b_wait--;
                end else begin
                    bvalid = 1'b1; bresp = 2'b00;
                    if (bready) b_pend = 1'b0;
                end
            end else begin
                bvalid = 1'b0;
            end
            if (w_active && wvalid) begin
                if (w_wait > 0) begin
                    wready = 1'b0; w_wait--;
                end else begin
                    wready = 1'b1;
                    check_eq("wdata", {32'd0, wdata}, {32'd0, exp_wb[32*w_beat +: 32]});
                    check_eq("wlast", {63'd0, wlast}, {63'd0, (w_beat == 15)});
                    w_beat++; w_wait = rnd();
                    if (w_beat == 16) begin w_active = 1'b0; b_pend = 1'b1; b_wait = rnd(); end
                end
            end else begin
                wready = 1'b0;
            end
            if (awvalid && !w_active && !b_pend) begin
                if (aw_wait > 0) begin
                    awready = 1'b0; aw_wait--;
                end else begin
                    awready = 1'b1; w_active = 1'b1; w_beat = 0; w_wait = rnd();
                end
            end else begin
                awready = 1'b0;
                if (!awvalid) aw_wait = rnd();
            end

            p_arv = arvalid; p_arr = arready; p_ara = araddr;
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_wd = wdata; p_wl = wlast;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {55'd0, arvalid, awvalid, wvalid, rready, bready,
                                accept, fin, wen_fill, wlast}, 64'd0);
        check_eq({tag, "_addr"}, {araddr, awaddr}, 64'd0);
        check_eq({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
        check_eq({tag, "_wfill"}, {63'd0, |wfill}, 64'd0);
        check_eq({tag, "_state"}, {61'd0, dut.state_q}, {61'd0, S_IDLE});
    endtask

    // Called at a negedge with the miss slot free.
    task automatic req_miss(input logic [31:0] a);
        miss = 1'b1; miss_addr = a;
        @(negedge clk);
        check_eq("accept_lat", {63'd0, accept}, 64'd1);
        miss = 1'b0;
    endtask

    task automatic wait_fill(input int n0, input string tag);
        int k = 0;
        while (fill_cnt == n0 && k < 800) begin @(negedge clk); k++; end
        check_eq({tag, "_fill"}, 64'(fill_cnt), 64'(n0 + 1));
    endtask

    task automatic check_words(input string tag, input logic [31:0] base);
        for (int i = 0; i < 16; i++)
            check_eq(tag, {32'd0, fill_line[32*i +: 32]}, {32'd0, base + 32'(i)});
    endtask

    initial begin
        int n0, f0, a0, k;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: zero-wait refill
        req_miss(32'h0000_1040);
        @(negedge clk);
        check_eq("t1_arvalid", {63'd0, arvalid}, 64'd1);
        check_eq("t1_araddr", {32'd0, araddr}, 64'h1040);
        check_eq("t1_burst", {49'd0, arlen, arsize, arburst, arid}, {49'd0, 8'd15, 3'd2, 2'b01, 4'd0});
        n0 = fill_cnt;
        wait_fill(n0, "t1");
        check_words("t1_word", 32'h1040_0000);
        check_eq("t1_latency", 64'(fill_cyc - ar_cyc), 64'd17);
        repeat (5) @(negedge clk);
        check_eq("t1_single_fill", 64'(fill_cnt), 64'(n0 + 1));

        // T2: simultaneous write-back and miss; write-back runs first
        for (int i = 0; i < 16; i++) exp_wb[32*i +: 32] = 32'(i);
        wback = exp_wb; waddr = 32'h0000_2000; wen_back = 1'b1;
        f0 = fin_cnt; n0 = fill_cnt;
        req_miss(32'h0000_3000);
        wen_back = 1'b0;
        wait_fill(n0, "t2");
        check_eq("t2_fin", 64'(fin_cnt), 64'(f0 + 1));
        check_eq("t2_awaddr", {32'd0, aw_addr_log}, 64'h2000);
        check_eq("t2_araddr", {32'd0, ar_addr_log}, 64'h3000);
        check_eq("t2_aw_before_ar", {63'd0, aw_cyc < ar_cyc}, 64'd1);
        check_eq("t2_fin_before_ar", {63'd0, fin_cyc < ar_cyc}, 64'd1);
        check_words("t2_word", 32'h3000_0000);

        // T3: random stalls on every slave channel
        stall_max = 5;
        for (int i = 0; i < 16; i++) exp_wb[32*i +: 32] = 32'hA500_0000 + 32'(i);
        wback = exp_wb; waddr = 32'h0000_4000; wen_back = 1'b1;
        f0 = fin_cnt; n0 = fill_cnt;
        @(negedge clk);
        wen_back = 1'b0;
        req_miss(32'h0000_5000);
        wait_fill(n0, "t3");
        k = 0;
        while (fin_cnt == f0 && k < 400) begin @(negedge clk); k++; end
        check_eq("t3_fin", 64'(fin_cnt), 64'(f0 + 1));
        check_words("t3_word", 32'h5000_0000);
        stall_max = 0;
        repeat (3) @(negedge clk);

        // T4: reset in the middle of the R burst
        n0 = fill_cnt;
        req_miss(32'h0000_6000);
        k = 0;
        while (!(r_active && r_beat == 7) && k < 100) begin @(negedge clk); k++; end
        check_eq("t4_reached_beat7", {63'd0, r_active}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t4_reset");
        check_eq("t4_no_fill", 64'(fill_cnt), 64'(n0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("t4_bus_err_clear", {63'd0, bus_err}, 64'd0);
        req_miss(32'h0000_7000);
        wait_fill(n0, "t4");
        check_words("t4_word", 32'h7000_0000);

        // T5: SLVERR on beat 3 -- data still used, flag set, no retry
        err_beat = 3;
        n0 = fill_cnt; a0 = ar_hs_cnt;
        req_miss(32'h0000_8000);
        wait_fill(n0, "t5");
        check_words("t5_word", 32'h8000_0000);
        check_eq("t5_bus_err", {63'd0, bus_err}, 64'd1);
        repeat (20) @(negedge clk);
        check_eq("t5_no_retry", 64'(ar_hs_cnt), 64'(a0 + 1));
        check_eq("t5_arvalid_idle", {63'd0, arvalid}, 64'd0);
        err_beat = -1;

        check_eq("protocol_violations", 64'(viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
